fifo_ctrl: RTL and testbench
============================

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of memory entries; must be a power of two.
REQ-002 SHALL have parameter PTR_W, default 3, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have parameter AF_THR, default 6; almost_full asserts when count >= AF_THR.
REQ-004 SHALL have parameter AE_THR, default 2; almost_empty asserts when count <= AE_THR.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port push, input, 1, upstream write request; data is presented directly to the memory.
REQ-008 SHALL have port pop, input, 1, downstream read request.
REQ-009 SHALL have port wr_ptr, output, PTR_W, memory write address.
REQ-010 SHALL have port rd_ptr, output, PTR_W, memory read address.
REQ-011 SHALL have port write, output, 1, memory write strobe.
REQ-012 SHALL have port read, output, 1, memory read strobe.
REQ-013 SHALL have port full, output, 1, asserted when count == DEPTH.
REQ-014 SHALL have port empty, output, 1, asserted when count == 0.
REQ-015 SHALL have port almost_full, output, 1, threshold flag.
REQ-016 SHALL have port almost_empty, output, 1, threshold flag.
REQ-017 SHALL have port count, output, PTR_W+1, current occupancy, 0..DEPTH.
REQ-018 SHALL have port valid_out, output, 1, memory q is valid this cycle.
REQ-019 SHALL have port overflow, output, 1, sticky flag for a rejected push.
REQ-020 SHALL have port underflow, output, 1, sticky flag for a rejected pop.

Function
REQ-021 SHALL compute write = push & ~full & reset (combinational); push is accepted only when write is 1.
REQ-022 SHALL compute read = pop & ~empty & reset (combinational); pop is accepted only when read is 1.
REQ-023 SHALL increment wr_ptr by 1 modulo DEPTH on each rising edge where write = 1, wrapping from 7 to 0.
REQ-024 SHALL increment rd_ptr by 1 modulo DEPTH on each rising edge where read = 1, wrapping from 7 to 0.
REQ-025 SHALL update count as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-026 SHALL never let count exceed DEPTH or go below 0.
REQ-027 SHALL derive full, empty, almost_full and almost_empty combinationally from the registered count.
REQ-028 SHALL register valid_out as the previous cycle's read, giving one-cycle read latency to memory q.
REQ-029 SHALL, when full and push=1 and pop=1: accept the pop, reject the push, and set overflow; count becomes DEPTH-1.
REQ-030 SHALL, when empty and push=1 and pop=1: accept the push, reject the pop, and set underflow; count becomes 1.
REQ-031 SHALL, when neither full nor empty and push=1 and pop=1: accept both; pointers both advance and count is unchanged.
REQ-032 SHALL set overflow on any edge with push & full, and keep it set until reset.
REQ-033 SHALL set underflow on any edge with pop & empty, and keep it set until reset.
REQ-034 SHALL drive wr_ptr == rd_ptr both when empty and when full; full and empty are distinguished by count only.

Reset
REQ-035 SHALL, on any rising edge with reset = 0, load wr_ptr=0, rd_ptr=0, count=0, valid_out=0, overflow=0 and underflow=0.
REQ-036 SHALL, while reset = 0, drive write=0, read=0, empty=1, full=0, almost_empty=1 and almost_full=0.
REQ-037 SHALL, when reset is asserted mid-operation, discard all pending contents; no write or read strobe issues during that cycle.
REQ-038 SHALL accept a push on the first rising edge after reset returns to 1.

Verification
REQ-039 SHALL verify fill to full: 8 consecutive pushes from reset -> wr_ptr 0..7 then 0, count=8, full=1, almost_full=1 from count 6, write=0 on a 9th push, overflow=1.
REQ-040 SHALL verify drain: 8 pops after fill -> rd_ptr wraps to 0, valid_out high 8 cycles each lagging read by 1, memory q matches the pushed sequence in order, empty=1, 9th pop sets underflow=1.
REQ-041 SHALL verify simultaneous push+pop at count=4 for 5 cycles -> count stays 4, both pointers advance by 5 modulo 8.
REQ-042 SHALL verify simultaneous push+pop when full -> read=1, write=0, count=7, overflow=1.
REQ-043 SHALL verify simultaneous push+pop when empty -> write=1, read=0, count=1, underflow=1.
REQ-044 SHALL verify reset at count=5 -> next edge gives pointers 0, count 0, flags cleared, empty=1; behavioural and synthesized memory outputs compared each cycle.

Source files
------------

// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the fifo_ctrl pointer/flag engine.
interface fifo_ctrl_if #(
    parameter int PTR_W = 3
);
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             write;
    logic             read;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [PTR_W:0]   count;
    logic             valid_out;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop,
        input  wr_ptr, rd_ptr, write, read, full, empty, almost_full, almost_empty,
        input  count, valid_out, overflow, underflow
    );

    modport slave (
        input  push, pop,
        output wr_ptr, rd_ptr, write, read, full, empty, almost_full, almost_empty,
        output count, valid_out, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller: generates memory addresses/strobes, occupancy count, threshold and sticky error flags.
module fifo_ctrl #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int AF_THR = 6,
    parameter int AE_THR = 2
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   AF_C    = (PTR_W+1)'(AF_THR);
    localparam logic [PTR_W:0]   AE_C    = (PTR_W+1)'(AE_THR);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             valid_q, ovf_q, ovf_d, unf_q, unf_d;
    logic             cnt_full, cnt_empty, write, read;

    // Occupancy alone separates full from empty since the pointers coincide in both.
    assign cnt_full  = (count_q == DEPTH_C);
    assign cnt_empty = (count_q == '0);

    // Reset gates strobes and forces the flags to their idle values.
    assign write = bus.push & ~cnt_full  & reset;
    assign read  = bus.pop  & ~cnt_empty & reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (bus.push & cnt_full);
        unf_d    = unf_q | (bus.pop  & cnt_empty);
        if (write) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (read)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({write, read})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= read;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.write        = write;
    assign bus.read         = read;
    assign bus.count        = count_q;
    assign bus.full         = reset & cnt_full;
    assign bus.empty        = ~reset | cnt_empty;
    assign bus.almost_full  = reset & (count_q >= AF_C);
    assign bus.almost_empty = ~reset | (count_q <= AE_C);
    assign bus.valid_out    = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural memory attached to its strobes.
module tb_fifo_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] mem [8];
    logic [7:0] q;
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int  m_cnt = 0, m_wp = 0, m_rp = 0;
    bit  m_ovf = 0, m_unf = 0, m_vld = 0;
    logic [7:0] exp_q [$];

    fifo_ctrl_if #(.PTR_W(3)) bus ();

    fifo_ctrl #(.DEPTH(8), .PTR_W(3), .AF_THR(6), .AE_THR(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.write) mem[bus.wr_ptr] <= din;
        if (bus.read)  q <= mem[bus.rd_ptr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: each valid_out beat must carry the oldest accepted, unread word.
    always @(negedge clk) begin
        if (bus.valid_out) begin
            if (exp_q.size() == 0) begin
                chk("valid_out_unexpected", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("q_data", int'(q), int'(e));
            end
        end
    end

    task automatic chk_state();
        chk("count",        int'(bus.count),        m_cnt);
        chk("wr_ptr",       int'(bus.wr_ptr),       m_wp);
        chk("rd_ptr",       int'(bus.rd_ptr),       m_rp);
        chk("full",         int'(bus.full),         int'(reset && m_cnt == 8));
        chk("empty",        int'(bus.empty),        int'(!reset || m_cnt == 0));
        chk("almost_full",  int'(bus.almost_full),  int'(reset && m_cnt >= 6));
        chk("almost_empty", int'(bus.almost_empty), int'(!reset || m_cnt <= 2));
        chk("overflow",     int'(bus.overflow),     int'(m_ovf));
        chk("underflow",    int'(bus.underflow),    int'(m_unf));
        chk("valid_out",    int'(bus.valid_out),    int'(m_vld));
    endtask

    // One clock: apply inputs just after an edge, check strobes, clock, check state.
    task automatic step(input bit rst, input bit p, input bit po, input logic [7:0] d);
        bit aw, ar;
        reset = rst; bus.push = p; bus.pop = po; din = d;
        aw = rst && p  && m_cnt != 8;
        ar = rst && po && m_cnt != 0;
        #2;
        chk("write", int'(bus.write), int'(aw));
        chk("read",  int'(bus.read),  int'(ar));
        if (aw) exp_q.push_back(d);
        @(posedge clk);
        if (!rst) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_vld = 0;
            exp_q.delete();
        end else begin
            if (p && m_cnt == 8)  m_ovf = 1;
            if (po && m_cnt == 0) m_unf = 1;
            if (aw) m_wp = (m_wp + 1) % 8;
            if (ar) m_rp = (m_rp + 1) % 8;
            m_cnt = m_cnt + int'(aw) - int'(ar);
            m_vld = ar;
        end
        #1;
        chk_state();
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0;
        @(posedge clk); #1;
        step(0, 1, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);

        // Fill to full, then a rejected ninth push
        for (int i = 0; i < 8; i++) begin
            chk("fill_wr_ptr", int'(bus.wr_ptr), i);
            step(1, 1, 0, 8'hA0 + 8'(i));
        end
        chk("fill_count", int'(bus.count), 8);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_wr_ptr_wrap", int'(bus.wr_ptr), 0);
        step(1, 1, 0, 8'hEE);
        chk("fill_ovf", int'(bus.overflow), 1);

        // Drain, then a rejected ninth pop
        for (int i = 0; i < 8; i++) step(1, 0, 1, 8'h00);
        chk("drain_rd_ptr_wrap", int'(bus.rd_ptr), 0);
        chk("drain_empty", int'(bus.empty), 1);
        step(1, 0, 1, 8'h00);
        chk("drain_unf", int'(bus.underflow), 1);

        // Simultaneous push+pop at count 4 for 5 cycles
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) step(1, 1, 1, 8'h20 + 8'(i));
        chk("pp4_count", int'(bus.count), 4);
        chk("pp4_wr_ptr", int'(bus.wr_ptr), 1);
        chk("pp4_rd_ptr", int'(bus.rd_ptr), 5);

        // Push+pop when full
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 8'h30 + 8'(i));
        step(1, 1, 1, 8'h3F);
        chk("ppf_count", int'(bus.count), 7);
        chk("ppf_ovf", int'(bus.overflow), 1);

        // Push+pop when empty
        step(0, 0, 0, 8'h00);
        step(1, 1, 1, 8'h55);
        chk("ppe_count", int'(bus.count), 1);
        chk("ppe_unf", int'(bus.underflow), 1);

        // Reset at count 5 with both requests active, then an immediate push
        for (int i = 0; i < 4; i++) step(1, 1, 0, 8'h60 + 8'(i));
        chk("pre_rst_count", int'(bus.count), 5);
        step(0, 1, 1, 8'h77);
        chk("mid_rst_count", int'(bus.count), 0);
        chk("mid_rst_ptr", int'(bus.wr_ptr) + int'(bus.rd_ptr), 0);
        chk("mid_rst_unf", int'(bus.underflow), 0);
        step(1, 1, 0, 8'h99);
        chk("post_rst_count", int'(bus.count), 1);
        step(1, 0, 1, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
